gfx_objdma_ctrl: RTL and testbench

//  Sprite attribute DMA controller for the gfx core. Once per frame, inside the timing generator's DMA window
//  (active-low, ~16 lines before VBLANK), copies NUM_WORDS bytes from the CPU-side object RAM into the sprite engine's

---
 rtl/gfx_pkg.sv | 19 +
 rtl/gfx_objdma_ctrl_if.sv | 49 ++++
 rtl/gfx_objdma_arb.sv | 22 ++
 rtl/gfx_objdma_ctrl.sv | 151 +++++++++++++++
 tb/tb_gfx_objdma_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gfx_pkg.sv
// Shared gfx definitions: object-DMA state encoding, default transfer size, DMA-window line numbers.
// Used by gfx_objdma_ctrl; the optional double-buffer build is selected with GFX_OBJDMA_DOUBLEBUF_EN.
package gfx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } objdma_state_e;

    localparam int OBJDMA_NUM_WORDS = 256;

    // DMA window lines, shared with the timing generator
    localparam int DMA_LINE_START = 479;
    localparam int DMA_LINE_END   = 494;

endpackage

// File: rtl/gfx_objdma_ctrl_if.sv
// Bus bundle between the object-DMA controller and CPU / object RAM / object buffer.
// With GFX_OBJDMA_DOUBLEBUF_EN the destination address carries one extra bank-select MSB.
interface gfx_objdma_ctrl_if #(
    parameter int SRC_AW = 11,
    parameter int DST_AW = 8
);
    import gfx_pkg::*;

`ifdef GFX_OBJDMA_DOUBLEBUF_EN
    localparam int DST_OW = DST_AW + 1;
`else
    localparam int DST_OW = DST_AW;
`endif

    // CPU handshake: i_CPU_REQ is held for the whole access; the access may proceed only
    // while o_CPU_GNT is high. o_CPU_WAIT_n is low whenever REQ is high without a grant.
    // Memory strobes: o_SRC_RD is a one-cycle read with data on i_SRC_DATA the next
    // enable-cycle; o_DST_WR is a one-cycle write of o_DST_DATA to o_DST_ADDR.
    logic                  i_EMU_CLK6MPCEN_n;
    logic                  i_DMA_n;
    logic [SRC_AW-1:0]     i_SRC_BASE;
    logic                  i_CPU_REQ;
    logic                  o_CPU_GNT;
    logic                  o_CPU_WAIT_n;
    logic [SRC_AW-1:0]     o_SRC_ADDR;
    logic                  o_SRC_RD;
    logic [7:0]            i_SRC_DATA;
    logic [DST_OW-1:0]     o_DST_ADDR;
    logic [7:0]            o_DST_DATA;
    logic                  o_DST_WR;
    logic                  o_BUSY;
    logic                  o_DONE;
    logic                  o_OVERRUN;
    logic                  o_BANK;
    objdma_state_e         dbg_state;

    modport slave (
        input  i_EMU_CLK6MPCEN_n, i_DMA_n, i_SRC_BASE, i_CPU_REQ, i_SRC_DATA,
        output o_CPU_GNT, o_CPU_WAIT_n, o_SRC_ADDR, o_SRC_RD, o_DST_ADDR, o_DST_DATA,
               o_DST_WR, o_BUSY, o_DONE, o_OVERRUN, o_BANK, dbg_state
    );

    modport master (
        output i_EMU_CLK6MPCEN_n, i_DMA_n, i_SRC_BASE, i_CPU_REQ, i_SRC_DATA,
        input  o_CPU_GNT, o_CPU_WAIT_n, o_SRC_ADDR, o_SRC_RD, o_DST_ADDR, o_DST_DATA,
               o_DST_WR, o_BUSY, o_DONE, o_OVERRUN, o_BANK, dbg_state
    );

endinterface

// File: rtl/gfx_objdma_arb.sv
// Object-RAM bus arbiter: registered CPU grant and combinational CPU wait.
module gfx_objdma_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic req,
    input  logic refuse,
    output logic gnt,
    output logic wait_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt <= 1'b0;
        end else if (ce) begin
            gnt <= req & ~refuse;
        end
    end

    assign wait_n = ~(req & ~gnt);

endmodule

// File: rtl/gfx_objdma_ctrl.sv
// Sprite attribute DMA: copies NUM_WORDS bytes from object RAM to the object buffer once per DMA window.
// GFX_OBJDMA_DOUBLEBUF_EN adds a bank MSB on the destination address and a bank toggle per completed frame.
module gfx_objdma_ctrl
    import gfx_pkg::*;
#(
    parameter int SRC_AW    = 11,
    parameter int DST_AW    = 8,
    parameter int NUM_WORDS = OBJDMA_NUM_WORDS
) (
    input  logic               i_EMU_MCLK,
    input  logic               i_MRST_n,
    gfx_objdma_ctrl_if.slave   bus
);

    localparam int CW = $clog2(NUM_WORDS + 1);
`ifdef GFX_OBJDMA_DOUBLEBUF_EN
    localparam int DST_OW = DST_AW + 1;
`else
    localparam int DST_OW = DST_AW;
`endif

    objdma_state_e     state, state_nx;
    logic              ce, dma_q, arm_edge, last;
    logic              busy, done, overrun, src_rd, dst_wr, bank;
    logic [SRC_AW-1:0] base, src_addr;
    logic [CW-1:0]     count;
    logic [CW:0]       count_inc;
    logic [DST_OW-1:0] dst_addr, dst_addr_nx;
    logic [7:0]        dst_data;
    logic              gnt, wait_n;

    assign ce        = ~bus.i_EMU_CLK6MPCEN_n;
    // dma_q resets low so a window already open at reset release is not an edge
    assign arm_edge  = dma_q & ~bus.i_DMA_n;
    assign count_inc = {1'b0, count} + {{CW{1'b0}}, 1'b1};
    assign last      = (count_inc >= (CW+1)'(NUM_WORDS));

`ifdef GFX_OBJDMA_DOUBLEBUF_EN
    assign dst_addr_nx = {~bank, DST_AW'(count)};
`else
    assign dst_addr_nx = DST_AW'(count);
`endif

    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state <= ST_IDLE;
        end else if (ce) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (arm_edge) state_nx = ST_ARM;
            ST_ARM: begin
                if (bus.i_DMA_n)          state_nx = ST_IDLE;
                else if (!bus.i_CPU_REQ)  state_nx = ST_READ;
            end
            ST_READ:  state_nx = ST_WRITE;
            // the byte in flight is always written; a closed window then aborts
            ST_WRITE: begin
                if (last)             state_nx = ST_DONE;
                else if (bus.i_DMA_n) state_nx = ST_IDLE;
                else                  state_nx = ST_READ;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            dma_q    <= 1'b0;
            base     <= '0;
            count    <= '0;
            src_addr <= '0;
            src_rd   <= 1'b0;
            dst_addr <= '0;
            dst_data <= '0;
            dst_wr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else if (ce) begin
            dma_q  <= bus.i_DMA_n;
            src_rd <= (state_nx == ST_READ);
            dst_wr <= 1'b0;
            done   <= 1'b0;
            if (state == ST_ARM && state_nx == ST_READ) begin
                base     <= bus.i_SRC_BASE;
                src_addr <= bus.i_SRC_BASE;
                count    <= '0;
                busy     <= 1'b1;
                overrun  <= 1'b0;
            end
            if (state == ST_WRITE) begin
                dst_wr   <= 1'b1;
                dst_data <= bus.i_SRC_DATA;
                dst_addr <= dst_addr_nx;
                count    <= count_inc[CW-1:0];
                src_addr <= base + SRC_AW'(count_inc);
            end
            if (state_nx == ST_DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if ((state == ST_ARM || state == ST_WRITE) && state_nx == ST_IDLE) begin
                overrun <= 1'b1;
                busy    <= 1'b0;
            end
        end
    end

`ifdef GFX_OBJDMA_DOUBLEBUF_EN
    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            bank <= 1'b0;
        end else if (ce && state_nx == ST_DONE) begin
            bank <= ~bank;
        end
    end
`else
    assign bank = 1'b0;
`endif

    // CPU stays refused from the DMA start through the DONE cycle
    gfx_objdma_arb u_arb (
        .clk    (i_EMU_MCLK),
        .rst_n  (i_MRST_n),
        .ce     (ce),
        .req    (bus.i_CPU_REQ),
        .refuse (busy | done),
        .gnt    (gnt),
        .wait_n (wait_n)
    );

    assign bus.o_CPU_GNT    = gnt;
    assign bus.o_CPU_WAIT_n = wait_n;
    assign bus.o_SRC_ADDR   = src_addr;
    assign bus.o_SRC_RD     = src_rd;
    assign bus.o_DST_ADDR   = dst_addr;
    assign bus.o_DST_DATA   = dst_data;
    assign bus.o_DST_WR     = dst_wr;
    assign bus.o_BUSY       = busy;
    assign bus.o_DONE       = done;
    assign bus.o_OVERRUN    = overrun;
    assign bus.o_BANK       = bank;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_gfx_objdma_ctrl.sv
// Directed testbench for gfx_objdma_ctrl; set GFX_OBJDMA_DOUBLEBUF_EN to exercise the bank-swap build.
module tb_gfx_objdma_ctrl;
  import gfx_pkg::*;

  localparam int SRC_AW = 11;
  localparam int DST_AW = 8;
  localparam int NW     = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gfx_objdma_ctrl_if #(.SRC_AW(SRC_AW), .DST_AW(DST_AW)) bus ();

  gfx_objdma_ctrl #(.SRC_AW(SRC_AW), .DST_AW(DST_AW), .NUM_WORDS(NW)) dut (
    .i_EMU_MCLK (clk),
    .i_MRST_n   (rst_n),
    .bus        (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  src_mem [0:2047];
  logic [7:0]  dst_mem [0:255];
  logic [7:0]  exp_q [$];
  logic [10:0] rd_log [0:31];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  logic        mon_clr = 1'b0;
  logic        wr_msb = 1'b0;
  logic        exp_bank = 1'b0;

  // object RAM, object buffer and strobe monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.i_EMU_CLK6MPCEN_n && bus.o_SRC_RD) bus.i_SRC_DATA <= src_mem[bus.o_SRC_ADDR];
    if (mon_clr) begin
      wr_cnt <= 0;
      rd_cnt <= 0;
      for (int i = 0; i < 256; i++) dst_mem[i] <= 8'hEE;
    end else if (!bus.i_EMU_CLK6MPCEN_n) begin
      if (bus.o_SRC_RD) begin
        if (rd_cnt < 32) rd_log[rd_cnt[4:0]] <= bus.o_SRC_ADDR;
        rd_cnt <= rd_cnt + 1;
      end
      if (bus.o_DST_WR) begin
        dst_mem[bus.o_DST_ADDR[DST_AW-1:0]] <= bus.o_DST_DATA;
`ifdef GFX_OBJDMA_DOUBLEBUF_EN
        wr_msb <= bus.o_DST_ADDR[DST_AW];
`endif
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && !bus.i_EMU_CLK6MPCEN_n && bus.o_DONE) done_cnt <= done_cnt + 1;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step(1);
    mon_clr = 1'b0;
  endtask

  task automatic fill_linear();
    for (int a = 0; a < 2048; a++) src_mem[a] = 8'(a);
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < 2048; a++) src_mem[a] = 8'h5A ^ 8'(a) ^ {3'(a >> 8), 5'b0};
  endtask

  task automatic note_done();
`ifdef GFX_OBJDMA_DOUBLEBUF_EN
    exp_bank = ~exp_bank;
`endif
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (bus.o_DONE === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [10:0] base, output bit seen, output int lat);
    int f;
    bus.i_SRC_BASE = base;
    bus.i_DMA_n = 1'b0;
    f = cyc;
    wait_done(1200, seen);
    lat = cyc - f;
    step(2);
    bus.i_DMA_n = 1'b1;
    step(3);
    if (seen) note_done();
  endtask

  task automatic test_reset();
    bus.i_EMU_CLK6MPCEN_n = 1'b0;
    bus.i_DMA_n = 1'b1;
    bus.i_SRC_BASE = '0;
    bus.i_CPU_REQ = 1'b0;
    rst_n = 1'b0;
    step(3);
    tests++;
    if ({bus.o_CPU_GNT, bus.o_CPU_WAIT_n, bus.o_SRC_RD, bus.o_DST_WR, bus.o_BUSY,
         bus.o_DONE, bus.o_OVERRUN, bus.o_BANK} !== 8'b0100_0000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 01000000", {bus.o_CPU_GNT, bus.o_CPU_WAIT_n,
               bus.o_SRC_RD, bus.o_DST_WR, bus.o_BUSY, bus.o_DONE, bus.o_OVERRUN, bus.o_BANK});
    end
    tests++;
    if (bus.o_SRC_ADDR !== '0 || bus.o_DST_ADDR !== '0 || bus.o_DST_DATA !== 8'h00 || bus.dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_regs: src=%0h dst=%0h data=%0h st=%0d expected all 0", bus.o_SRC_ADDR,
               bus.o_DST_ADDR, bus.o_DST_DATA, bus.dbg_state);
    end
    rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_full();
    bit seen;
    int lat, bad, d0;
    fill_linear();
    clear_mon();
    for (int n = 0; n < NW; n++) exp_q.push_back(8'(n));
    d0 = done_cnt;
    run_frame(11'h100, seen, lat);
    tests++;
    if (!seen || lat != 514) begin
      fails++;
      $display("FAIL full_done_time: seen=%0b cycle=%0d expected 514", seen, lat);
    end
    bad = 0;
    for (int n = 0; n < NW; n++) if (dst_mem[n] !== exp_q.pop_front()) bad++;
    tests++;
    if (bad != 0 || wr_cnt != NW) begin
      fails++;
      $display("FAIL full_data: bad=%0d writes=%0d expected 0 bad, 256 writes", bad, wr_cnt);
    end
    tests++;
    if (done_cnt - d0 != 1 || bus.o_OVERRUN !== 1'b0 || bus.o_BANK !== exp_bank) begin
      fails++;
      $display("FAIL full_status: dones=%0d ovr=%0b bank=%0b expected 1 0 %0b", done_cnt - d0,
               bus.o_OVERRUN, bus.o_BANK, exp_bank);
    end
  endtask

  task automatic test_cpu_hold();
    bit seen, bad;
    bus.i_CPU_REQ = 1'b1;
    step(1);
    tests++;
    if (bus.o_CPU_GNT !== 1'b1 || bus.o_CPU_WAIT_n !== 1'b1) begin
      fails++;
      $display("FAIL cpu_grant: gnt=%0b wait_n=%0b expected 1 1", bus.o_CPU_GNT, bus.o_CPU_WAIT_n);
    end
    step(4);
    bus.i_SRC_BASE = 11'h100;
    bus.i_DMA_n = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (bus.o_BUSY !== 1'b0 || bus.o_CPU_GNT !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad || bus.dbg_state !== ST_ARM) begin
      fails++;
      $display("FAIL cpu_held: bad=%0b st=%0d expected 0 and ARM", bad, bus.dbg_state);
    end
    bus.i_CPU_REQ = 1'b0;
    step(1);
    tests++;
    if (bus.o_BUSY !== 1'b1 || bus.o_CPU_GNT !== 1'b0) begin
      fails++;
      $display("FAIL cpu_busy_rise: busy=%0b gnt=%0b expected 1 0", bus.o_BUSY, bus.o_CPU_GNT);
    end
    step(10);
    bus.i_CPU_REQ = 1'b1;
    #1;
    tests++;
    if (bus.o_CPU_WAIT_n !== 1'b0 || bus.o_CPU_GNT !== 1'b0) begin
      fails++;
      $display("FAIL cpu_wait: wait_n=%0b gnt=%0b expected 0 0", bus.o_CPU_WAIT_n, bus.o_CPU_GNT);
    end
    seen = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      step(1);
      if (bus.o_CPU_WAIT_n !== 1'b0) bad = 1'b1;
      if (bus.o_DONE === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || bad) begin
      fails++;
      $display("FAIL cpu_wait_hold: done_seen=%0b wait_released_early=%0b expected 1 0", seen, bad);
    end
    if (seen) note_done();
    step(2);
    tests++;
    if (bus.o_CPU_GNT !== 1'b1 || bus.o_BUSY !== 1'b0) begin
      fails++;
      $display("FAIL cpu_regrant: gnt=%0b busy=%0b expected 1 0", bus.o_CPU_GNT, bus.o_BUSY);
    end
    bus.i_CPU_REQ = 1'b0;
    bus.i_DMA_n = 1'b1;
    step(3);
  endtask

  task automatic test_wrap();
    bit seen;
    int lat, bad;
    objdma_state_e s0;
    logic [10:0] a0;
    fill_pattern();
    clear_mon();
    bus.i_SRC_BASE = 11'h7F0;
    bus.i_DMA_n = 1'b0;
    step(40);
    bus.i_EMU_CLK6MPCEN_n = 1'b1;
    s0 = bus.dbg_state;
    a0 = bus.o_SRC_ADDR;
    step(6);
    tests++;
    if (bus.dbg_state !== s0 || bus.o_SRC_ADDR !== a0) begin
      fails++;
      $display("FAIL enable_hold: st=%0d addr=%0h expected %0d %0h", bus.dbg_state, bus.o_SRC_ADDR, s0, a0);
    end
    bus.i_EMU_CLK6MPCEN_n = 1'b0;
    wait_done(1200, seen);
    lat = 0;
    step(2);
    bus.i_DMA_n = 1'b1;
    step(3);
    if (seen) note_done();
    tests++;
    if (rd_log[0] !== 11'h7F0 || rd_log[15] !== 11'h7FF || rd_log[16] !== 11'h000) begin
      fails++;
      $display("FAIL wrap_addr: rd0=%0h rd15=%0h rd16=%0h expected 7f0 7ff 0", rd_log[0], rd_log[15], rd_log[16]);
    end
    tests++;
    if (dst_mem[15] !== 8'h45 || dst_mem[16] !== 8'h5A) begin
      fails++;
      $display("FAIL wrap_data: dst15=%0h dst16=%0h expected 45 5a", dst_mem[15], dst_mem[16]);
    end
    for (int n = 0; n < NW; n++) exp_q.push_back(src_mem[(11'h7F0 + n) % 2048]);
    bad = 0;
    for (int n = 0; n < NW; n++) if (dst_mem[n] !== exp_q.pop_front()) bad++;
    tests++;
    if (!seen || bad != 0) begin
      fails++;
      $display("FAIL wrap_all: done_seen=%0b bad=%0d expected 1 0", seen, bad);
    end
  endtask

  task automatic test_arm_abort();
    bus.i_CPU_REQ = 1'b1;
    step(2);
    bus.i_DMA_n = 1'b0;
    step(3);
    bus.i_DMA_n = 1'b1;
    step(2);
    tests++;
    if (bus.dbg_state !== ST_IDLE || bus.o_OVERRUN !== 1'b1 || bus.o_BUSY !== 1'b0 || bus.o_CPU_GNT !== 1'b1) begin
      fails++;
      $display("FAIL arm_abort: st=%0d ovr=%0b busy=%0b gnt=%0b expected IDLE 1 0 1", bus.dbg_state,
               bus.o_OVERRUN, bus.o_BUSY, bus.o_CPU_GNT);
    end
    bus.i_CPU_REQ = 1'b0;
    step(2);
  endtask

  task automatic test_window_loss();
    int d0;
    fill_linear();
    clear_mon();
    d0 = done_cnt;
    bus.i_SRC_BASE = 11'h100;
    bus.i_DMA_n = 1'b0;
    step(100);
    tests++;
    if (bus.o_OVERRUN !== 1'b0 || bus.o_BUSY !== 1'b1) begin
      fails++;
      $display("FAIL loss_start: ovr=%0b busy=%0b expected 0 1", bus.o_OVERRUN, bus.o_BUSY);
    end
    step(200);
    bus.i_DMA_n = 1'b1;
    step(10);
    tests++;
    if (wr_cnt != 150 || dst_mem[149] !== 8'd149 || dst_mem[150] !== 8'hEE) begin
      fails++;
      $display("FAIL loss_writes: writes=%0d dst149=%0h dst150=%0h expected 150 95 ee", wr_cnt,
               dst_mem[149], dst_mem[150]);
    end
    tests++;
    if (bus.o_OVERRUN !== 1'b1 || done_cnt != d0 || bus.o_BANK !== exp_bank ||
        bus.dbg_state !== ST_IDLE || bus.o_BUSY !== 1'b0) begin
      fails++;
      $display("FAIL loss_status: ovr=%0b dones=%0d bank=%0b st=%0d busy=%0b expected 1 0 %0b IDLE 0",
               bus.o_OVERRUN, done_cnt - d0, bus.o_BANK, bus.dbg_state, bus.o_BUSY, exp_bank);
    end
  endtask

  task automatic test_recover();
    bit seen;
    int lat;
    clear_mon();
    run_frame(11'h100, seen, lat);
    tests++;
    if (!seen || bus.o_OVERRUN !== 1'b0 || wr_cnt != NW || dst_mem[255] !== 8'hFF) begin
      fails++;
      $display("FAIL recover: done_seen=%0b ovr=%0b writes=%0d dst255=%0h expected 1 0 256 ff", seen,
               bus.o_OVERRUN, wr_cnt, dst_mem[255]);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    fill_linear();
    clear_mon();
    d0 = done_cnt;
    bus.i_SRC_BASE = 11'h100;
    bus.i_DMA_n = 1'b0;
    for (int i = 0; i < 600 && wr_cnt < 100; i++) step(1);
    tests++;
    if (wr_cnt < 100) begin
      fails++;
      $display("FAIL areset_reach: writes=%0d expected 100", wr_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.o_CPU_GNT, bus.o_CPU_WAIT_n, bus.o_SRC_RD, bus.o_DST_WR, bus.o_BUSY, bus.o_DONE,
         bus.o_OVERRUN, bus.o_BANK} !== 8'b0100_0000 || bus.o_SRC_ADDR !== '0 ||
        bus.o_DST_ADDR !== '0 || bus.dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL areset_outputs: flags=%b src=%0h dst=%0h st=%0d expected 01000000 0 0 IDLE",
               {bus.o_CPU_GNT, bus.o_CPU_WAIT_n, bus.o_SRC_RD, bus.o_DST_WR, bus.o_BUSY, bus.o_DONE,
                bus.o_OVERRUN, bus.o_BANK}, bus.o_SRC_ADDR, bus.o_DST_ADDR, bus.dbg_state);
    end
    exp_bank = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(20);
    tests++;
    if (bus.dbg_state !== ST_IDLE || bus.o_BUSY !== 1'b0 || done_cnt != d0) begin
      fails++;
      $display("FAIL areset_no_rearm: st=%0d busy=%0b dones=%0d expected IDLE 0 0", bus.dbg_state,
               bus.o_BUSY, done_cnt - d0);
    end
    bus.i_DMA_n = 1'b1;
    step(3);
  endtask

  task automatic test_bank();
    bit seen;
    int lat;
    logic b_before;
    for (int fr = 0; fr < 2; fr++) begin
      b_before = exp_bank;
      clear_mon();
      run_frame(11'h100, seen, lat);
      tests++;
      if (!seen || bus.o_BANK !== exp_bank) begin
        fails++;
        $display("FAIL bank_frame%0d: done_seen=%0b bank=%0b expected 1 %0b", fr, seen, bus.o_BANK, exp_bank);
      end
`ifdef GFX_OBJDMA_DOUBLEBUF_EN
      tests++;
      if (wr_msb !== ~b_before || bus.o_BANK !== ~b_before) begin
        fails++;
        $display("FAIL bank_msb%0d: wr_msb=%0b bank=%0b expected %0b %0b", fr, wr_msb, bus.o_BANK,
                 ~b_before, ~b_before);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_cpu_hold();
    test_wrap();
    test_arm_abort();
    test_window_loss();
    test_recover();
    test_async_reset();
    test_bank();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
